// File: rtl/vpu_dst_port_if.sv
// rtl/vpu_dst_port_if.sv - handshake and SRAM write bundle for the VPU destination port
//
// Groups everything between the controller/ALU, the destination port and the
// SRAM write port. The slave modport is the destination port's view. The master
// modport is the view of whatever drives it (controller, ALU, SRAM).
//   start_i/base_addr_i/len_i          : transfer launch from the controller
//   result_i/result_valid_i/result_ready_o : ALU result stream
//   sram_w_en_o/addr/data, sram_w_ready_i  : SRAM write request
//   busy_o/done_o                       : status back to the controller
interface vpu_dst_port_if #(
    parameter int OPERAND_WIDTH = 16,
    parameter int ADDR_WIDTH    = 10
);
    logic                     start_i;
    logic [ADDR_WIDTH-1:0]    base_addr_i;
    logic [ADDR_WIDTH:0]      len_i;
    logic [OPERAND_WIDTH-1:0] result_i;
    logic                     result_valid_i;
    logic                     result_ready_o;
    logic                     sram_w_en_o;
    logic [ADDR_WIDTH-1:0]    sram_w_addr_o;
    logic [OPERAND_WIDTH-1:0] sram_w_data_o;
    logic                     sram_w_ready_i;
    logic                     busy_o;
    logic                     done_o;

    modport slave (
        input  start_i, base_addr_i, len_i, result_i, result_valid_i, sram_w_ready_i,
        output result_ready_o, sram_w_en_o, sram_w_addr_o, sram_w_data_o, busy_o, done_o
    );

    modport master (
        output start_i, base_addr_i, len_i, result_i, result_valid_i, sram_w_ready_i,
        input  result_ready_o, sram_w_en_o, sram_w_addr_o, sram_w_data_o, busy_o, done_o
    );
endinterface

// File: rtl/vpu_dst_port.sv
// rtl/vpu_dst_port.sv - VPU destination port: buffers ALU results and writes them to SRAM
//
// Ports:
//   clk   : clock
//   rst_n : asynchronous active-low reset
//   bus   : vpu_dst_port_if.slave (start/base/len, result stream, SRAM write, busy/done)
//
// A start in IDLE latches base and length. Accepted results go through a small
// FIFO and are written to base, base+1, ... (wrapping in the address space).
// done_o pulses for one cycle after the last write commits.
module vpu_dst_port #(
    parameter int OPERAND_WIDTH = 16,
    parameter int ADDR_WIDTH    = 10,
    parameter int FIFO_DEPTH    = 4
) (
    input  logic           clk,
    input  logic           rst_n,
    vpu_dst_port_if.slave  bus
);
    localparam int PW = $clog2(FIFO_DEPTH);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RUN  = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    logic [1:0]               state;
    logic [ADDR_WIDTH-1:0]    base_q;
    logic [ADDR_WIDTH:0]      len_q;
    logic [ADDR_WIDTH:0]      acc_cnt;
    logic [ADDR_WIDTH:0]      wr_cnt;
    logic [ADDR_WIDTH:0]      wr_next;

    logic [OPERAND_WIDTH-1:0] mem [FIFO_DEPTH];
    // Pointers carry one extra wrap bit so full and empty are distinguishable.
    logic [PW:0]              wptr;
    logic [PW:0]              rptr;
    logic                     empty;
    logic                     full;

    logic                     run;
    logic                     ready;
    logic                     en;
    logic                     push;
    logic                     pop;
    logic                     last_write;
    logic [OPERAND_WIDTH-1:0] head;
    logic [ADDR_WIDTH-1:0]    cur_addr;
    logic [OPERAND_WIDTH-1:0] last_data;
    logic [ADDR_WIDTH-1:0]    last_addr;

    assign empty = (wptr == rptr);
    assign full  = (wptr[PW] != rptr[PW]) && (wptr[PW-1:0] == rptr[PW-1:0]);

    assign run   = (state == S_RUN);
    // Built from registered state only, so there is no path from valid or sram ready.
    assign ready = run && !full && (acc_cnt < len_q);
    assign en    = run && !empty;
    assign push  = bus.result_valid_i && ready;
    assign pop   = en && bus.sram_w_ready_i;

    assign head       = mem[rptr[PW-1:0]];
    assign cur_addr   = base_q + wr_cnt[ADDR_WIDTH-1:0];
    assign wr_next    = wr_cnt + {{ADDR_WIDTH{1'b0}}, 1'b1};
    assign last_write = pop && (wr_next == len_q);

    assign bus.result_ready_o = ready;
    assign bus.sram_w_en_o    = en;
    // While idle or stalled on an empty FIFO, address and data show the last presented request.
    assign bus.sram_w_addr_o  = en ? cur_addr : last_addr;
    assign bus.sram_w_data_o  = en ? head : last_data;
    assign bus.busy_o         = (state != S_IDLE);
    assign bus.done_o         = (state == S_DONE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= S_IDLE;
            base_q    <= '0;
            len_q     <= '0;
            acc_cnt   <= '0;
            wr_cnt    <= '0;
            wptr      <= '0;
            rptr      <= '0;
            last_addr <= '0;
            last_data <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (bus.start_i) begin
                        if (bus.len_i != '0) begin
                            base_q  <= bus.base_addr_i;
                            len_q   <= bus.len_i;
                            acc_cnt <= '0;
                            wr_cnt  <= '0;
                            wptr    <= '0;
                            rptr    <= '0;
                            state   <= S_RUN;
                        end else begin
                            state   <= S_DONE;
                        end
                    end
                end
                S_RUN: begin
                    if (push) begin
                        wptr    <= wptr + {{PW{1'b0}}, 1'b1};
                        acc_cnt <= acc_cnt + {{ADDR_WIDTH{1'b0}}, 1'b1};
                    end
                    if (pop) begin
                        rptr   <= rptr + {{PW{1'b0}}, 1'b1};
                        wr_cnt <= wr_next;
                    end
                    if (last_write) begin
                        state <= S_DONE;
                    end
                end
                S_DONE: begin
                    state <= S_IDLE;
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase

            if (en) begin
                last_addr <= cur_addr;
                last_data <= head;
            end
        end
    end

    // Storage needs no reset: entries are only read once the pointers say they are valid.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wptr[PW-1:0]] <= bus.result_i;
        end
    end
endmodule
